// File: rtl/jk_bank_arbiter_if.sv
// Request/grant bus between control agents and the shared JK flag bank.
// Handshake: a request transfers at a rising clk edge when req_valid[i] & req_ready[i].
interface jk_bank_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int NBITS = 8,
  parameter int AW    = 3,
  parameter int IDW   = 2
);
  logic                 freeze;
  logic [NREQ-1:0]      req_valid;
  logic [2*NREQ-1:0]    req_op;
  logic [AW*NREQ-1:0]   req_addr;
  logic [NREQ-1:0]      req_ready;
  logic [NBITS-1:0]     q;
  logic                 done_valid;
  logic [IDW-1:0]       done_id;
  logic                 done_err;

  modport master (
    output freeze, req_valid, req_op, req_addr,
    input  req_ready, q, done_valid, done_id, done_err
  );

  modport slave (
    input  freeze, req_valid, req_op, req_addr,
    output req_ready, q, done_valid, done_id, done_err
  );
endinterface

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter granting one JK op per cycle into a shared flag bank.
// Grant is combinational; the op is staged one cycle and applied with SR logic.
module jk_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int NBITS = 8,
  parameter int AW    = 3,
  parameter int IDW   = 2
) (
  input logic              clk,
  input logic              rst,
  jk_bank_arbiter_if.slave bus
);

  logic [IDW-1:0]   ptr_q, ptr_d;
  logic             found_hi, found_lo;
  logic [IDW-1:0]   win_hi, win_lo, win_id;
  logic             grant;
  logic [NREQ-1:0]  ready;
  logic [1:0]       sel_op;
  logic [AW-1:0]    sel_addr;

  logic             stg_valid_q;
  logic [IDW-1:0]   stg_id_q;
  logic [1:0]       stg_op_q;
  logic [AW-1:0]    stg_addr_q;

  logic [NBITS-1:0] q_q, q_d;
  logic             done_valid_q;
  logic [IDW-1:0]   done_id_q;
  logic             done_err_q;
  logic             addr_err;
  logic             set_bit, clr_bit;

  // Winner is the first valid at or above ptr, else the lowest valid below it.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (bus.req_valid[i] && !found_hi && (i >= int'(ptr_q))) begin
        found_hi = 1'b1;
        win_hi   = IDW'(i);
      end
      if (bus.req_valid[i] && !found_lo) begin
        found_lo = 1'b1;
        win_lo   = IDW'(i);
      end
    end
    win_id = found_hi ? win_hi : win_lo;
    grant  = found_lo && !bus.freeze && !rst;
    ready  = grant ? (NREQ'(1) << win_id) : '0;
  end

  always_comb begin
    sel_op   = '0;
    sel_addr = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_id == IDW'(i)) begin
        sel_op   = bus.req_op[2*i +: 2];
        sel_addr = bus.req_addr[AW*i +: AW];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant) begin
      ptr_d = (int'(win_id) == NREQ - 1) ? '0 : win_id + 1'b1;
    end
  end

  // Apply stage: s = j & ~q, r = k & q, evaluated on the current bank value.
  always_comb begin
    q_d      = q_q;
    set_bit  = 1'b0;
    clr_bit  = 1'b0;
    addr_err = int'(stg_addr_q) >= NBITS;
    for (int b = 0; b < NBITS; b++) begin
      if (stg_valid_q && (stg_addr_q == AW'(b))) begin
        set_bit = stg_op_q[1] & ~q_q[b];
        clr_bit = stg_op_q[0] &  q_q[b];
        if (set_bit) begin
          q_d[b] = 1'b1;
        end else if (clr_bit) begin
          q_d[b] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q        <= '0;
      stg_valid_q  <= 1'b0;
      stg_id_q     <= '0;
      stg_op_q     <= '0;
      stg_addr_q   <= '0;
      q_q          <= '0;
      done_valid_q <= 1'b0;
      done_id_q    <= '0;
      done_err_q   <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      stg_valid_q <= grant;
      if (grant) begin
        stg_id_q   <= win_id;
        stg_op_q   <= sel_op;
        stg_addr_q <= sel_addr;
      end
      q_q          <= q_d;
      done_valid_q <= stg_valid_q;
      if (stg_valid_q) begin
        done_id_q <= stg_id_q;
      end
      done_err_q <= stg_valid_q & addr_err;
    end
  end

  assign bus.req_ready  = ready;
  assign bus.q          = q_q;
  assign bus.done_valid = done_valid_q;
  assign bus.done_id    = done_id_q;
  assign bus.done_err   = done_err_q;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Bench for jk_bank_arbiter: directed scenarios with literal expectations plus
// randomized traffic, all compared each cycle against a behavioural bank model.
module tb_jk_bank_arbiter;
  localparam int NREQ  = 4;
  localparam int NBITS = 6;
  localparam int AW    = 3;
  localparam int IDW   = 2;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  bit   rand_rst;

  jk_bank_arbiter_if #(.NREQ(NREQ), .NBITS(NBITS), .AW(AW), .IDW(IDW)) bus ();

  jk_bank_arbiter #(.NREQ(NREQ), .NBITS(NBITS), .AW(AW), .IDW(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int               m_ptr = 0;
  bit [NBITS-1:0]   m_q = '0;
  bit               pend_v = 0;
  int               pend_id, pend_op, pend_addr;
  bit               exp_dv = 0;
  int               exp_did = 0;
  bit               exp_derr = 0;

  function automatic int m_winner();
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (m_ptr + k) % NREQ;
      if (bus.req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr    = 0;
    m_q      = '0;
    pend_v   = 0;
    exp_dv   = 0;
    exp_did  = 0;
    exp_derr = 0;
  endtask

  task automatic model_step();
    int w;
    exp_dv = pend_v;
    if (pend_v) begin
      exp_did  = pend_id;
      exp_derr = (pend_addr >= NBITS);
      if (pend_addr < NBITS) begin
        case (pend_op)
          1: m_q[pend_addr] = 1'b0;
          2: m_q[pend_addr] = 1'b1;
          3: m_q[pend_addr] = ~m_q[pend_addr];
          default: ;
        endcase
      end
    end else begin
      exp_derr = 0;
    end
    w = m_winner();
    if (!bus.freeze && w >= 0) begin
      pend_v    = 1;
      pend_id   = w;
      pend_op   = int'(bus.req_op[2*w +: 2]);
      pend_addr = int'(bus.req_addr[AW*w +: AW]);
      m_ptr     = (w + 1) % NREQ;
    end else begin
      pend_v = 0;
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) model_reset();
    else model_step();
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    int w;
    int exp_ready;
    @(negedge clk);
    w = m_winner();
    exp_ready = (rst || bus.freeze || w < 0) ? 0 : (1 << w);
    check("req_ready", int'(bus.req_ready), exp_ready);
    check("q", int'(bus.q), int'(m_q));
    check("done_valid", int'(bus.done_valid), int'(exp_dv));
    if (exp_dv) begin
      check("done_id", int'(bus.done_id), exp_did);
      check("done_err", int'(bus.done_err), int'(exp_derr));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    bus.freeze    = 1'b0;
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_addr  = '0;
  endtask

  task automatic drive_req(input int i, input logic [1:0] op, input int addr);
    bus.req_valid[i]         = 1'b1;
    bus.req_op[2*i +: 2]     = op;
    bus.req_addr[AW*i +: AW] = AW'(addr);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int op_seq [6] = '{0, 2, 2, 1, 3, 0};
    int q_seq  [6] = '{0, 4, 4, 0, 4, 4};

    rst = 1'b0;
    drive_idle();
    #2 rst = 1'b1;

    // Reset with every requester asking to set its own bit.
    for (int i = 0; i < NREQ; i++) drive_req(i, 2'b10, i);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", int'(bus.req_ready), 0);
    check("rst_q", int'(bus.q), 0);
    check("rst_done", int'(bus.done_valid), 0);

    // Round robin: grants 0,1,2,3,0, done ids trail by two negedges.
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k <= 4) check("rr_grant", int'(bus.req_ready), 1 << (k % 4));
      if (k >= 2) begin
        check("rr_done_valid", int'(bus.done_valid), 1);
        check("rr_done_id", int'(bus.done_id), k - 2);
      end
      if (k == 5) check("rr_q", int'(bus.q), 'h0F);
    end
    @(posedge clk);
    #1 drive_idle();

    // Same-bit toggles back to back.
    pulse_reset();
    drive_req(1, 2'b11, 5);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("haz_q1", int'(bus.q), 32);
    @(posedge clk);
    #1 drive_idle();
    @(negedge clk);
    check("haz_q2", int'(bus.q), 0);
    @(negedge clk);
    check("haz_q3", int'(bus.q), 32);
    check("haz_id", int'(bus.done_id), 1);

    // Op coverage on bit 2.
    pulse_reset();
    for (int s = 0; s < 6; s++) begin
      drive_req(0, 2'(op_seq[s]), 2);
      @(posedge clk);
      #1 drive_idle();
      @(posedge clk);
      @(negedge clk);
      check("opcov_q", int'(bus.q), q_seq[s]);
    end

    // Out-of-range address: dropped with error.
    drive_req(2, 2'b10, 7);
    @(posedge clk);
    #1 drive_idle();
    @(posedge clk);
    @(negedge clk);
    check("err_flag", int'(bus.done_err), 1);
    check("err_id", int'(bus.done_id), 2);
    check("err_q", int'(bus.q), 4);

    // Freeze blocks grants; released requester wins immediately.
    bus.freeze = 1'b1;
    drive_req(3, 2'b10, 0);
    repeat (3) begin
      @(negedge clk);
      check("frz_ready", int'(bus.req_ready), 0);
    end
    @(posedge clk);
    #1 bus.freeze = 1'b0;
    @(negedge clk);
    check("frz_release", int'(bus.req_ready), 8);
    @(posedge clk);
    #1 drive_idle();

    // Reset lands between handshake and apply.
    pulse_reset();
    drive_req(0, 2'b10, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check("midrst_q", int'(bus.q), 0);
    check("midrst_done", int'(bus.done_valid), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    drive_idle();
    @(negedge clk);
    check("midrst_q_after", int'(bus.q), 0);
    check("midrst_done_after", int'(bus.done_valid), 0);

    // Randomized traffic, including bad addresses, freeze and async resets.
    rand_rst = 0;
    repeat (2000) begin
      @(posedge clk);
      #1;
      if (rand_rst) begin
        rst = 1'b0;
        rand_rst = 0;
      end
      bus.freeze = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < NREQ; i++) begin
        bus.req_valid[i]         = ($urandom_range(0, 2) != 0);
        bus.req_op[2*i +: 2]     = 2'($urandom_range(0, 3));
        bus.req_addr[AW*i +: AW] = AW'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 99) == 0) begin
        #2 rst = 1'b1;
        rand_rst = 1;
      end
    end
    @(posedge clk);
    #1 rst = 1'b0;
    drive_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
